writeback_queue: RTL and testbench
==================================

// Module: writeback_queue
// PURPOSE
// - Write-side front end of the 32x16 register file: accepts writeback requests from the ALU and
//   memory-load paths, queues them in order, and drives the register file's single write port
//   (reg_write/waddr/wdata).
// - Gives decode a forwarding lookup, so values still waiting in the queue can be read before they
//   reach the register file.
// PARAMETERS
// - DATA_W       16  data width; must match the register file.
// - DEPTH         4  number of queue entries; power of two, >= 2.
// - DROP_R0       1  1: address-0 writes complete the handshake but are not queued. 0: address 0 is an ordinary register.
// PORTS
// - clk          in   1       system clock; all state changes on the rising edge.
// - arst_n       in   1       reset, synchronous, active-low.
// - mem_valid    in   1       load result is valid.
// - mem_ready    out  1       queue accepts the load result.
// - mem_waddr    in   5       destination register of the load.
// - mem_wdata    in   DATA_W  load data.
// - alu_valid    in   1       ALU result is valid.
// - alu_ready    out  1       queue accepts the ALU result.
// - alu_waddr    in   5       destination register of the ALU result.
// - alu_wdata    in   DATA_W  ALU result data.
// - wb_hold      in   1       1 = write port borrowed; the queue must not drain this cycle.
// - reg_write    out  1       write enable to the register file.
// - waddr        out  5       register-file write address.
// - wdata        out  DATA_W  register-file write data.
// - fwd_raddr_1  in   5       forwarding lookup address, port 1.
// - fwd_raddr_2  in   5       forwarding lookup address, port 2.
// - fwd_hit_1    out  1       fwd_raddr_1 matches a queued entry.
// - fwd_hit_2    out  1       fwd_raddr_2 matches a queued entry.
// - fwd_data_1   out  DATA_W  forwarded data, port 1.
// - fwd_data_2   out  DATA_W  forwarded data, port 2.
// - wb_idle      out  1       queue is empty.
// BEHAVIOUR
// - Storage: circular FIFO of DEPTH {addr,data} entries with wr_ptr, rd_ptr and count (0..DEPTH).
// - Reset (arst_n=0 at an edge): pointers, count and all entries are cleared to 0.
//   The queue is empty, so reg_write=0, waddr=0, wdata=0, fwd_hit_*=0, fwd_data_*=0, wb_idle=1.
//   A reset in mid-operation discards queued writes and ignores any handshake in that cycle.
// - Handshake: a transfer happens when valid&&ready at a rising edge. Sources hold addr and data stable until accepted.
//   - mem_ready = (count != DEPTH).
//   - alu_ready = (count != DEPTH) && !mem_valid. Memory has fixed priority; at most one enqueue per cycle.
// - Full: ready is low whenever count == DEPTH, even if a dequeue happens in the same cycle (no pass-through).
// - DROP_R0=1 and the accepted addr is 0: the handshake completes and nothing is enqueued.
// - Write port (combinational from the queue head):
//   - reg_write = (count != 0) && !wb_hold.
//   - waddr/wdata = head entry when count != 0, else 0.
//   - When reg_write=1, the head is dequeued at the same edge that the register file captures it.
// - Latency: accepted at edge N -> reg_write high during cycle N..N+1 -> register file updated at edge N+1
//   (queue previously empty, no hold).
// - Simultaneous enqueue and dequeue: count is unchanged and both pointers advance.
// - Pointer wrap: pointers wrap modulo DEPTH; count is the sole full/empty indicator.
// - Order: writes leave in acceptance order, including repeated writes to the same register.
// - wb_hold=1: reg_write=0, no dequeue, enqueue still allowed until full; waddr/wdata still show the head.
// - Forwarding (combinational):
//   - Each port compares its address against all valid entries.
//   - On multiple matches, the youngest (closest to wr_ptr) wins.
//   - No match: hit=0, data=0.
//   - The head entry being written this cycle still counts as a hit.
//   - An entry being enqueued this cycle is not visible until the next cycle.
// - wb_idle = (count == 0).
// TESTING
// - T1 reset: arst_n=0 for 2 cycles with both valids high -> no acceptance, reg_write=0, wb_idle=1, fwd_hit_*=0.
// - T2 single write: alu r5=16'h1234 accepted at edge N -> reg_write=1, waddr=5, wdata=16'h1234 in cycle N..N+1;
//   wb_idle=1 after edge N+1.
// - T3 priority: mem r3=16'hAAAA and alu r4=16'h5555 valid together -> mem accepted first, alu_ready=0;
//   alu accepted next cycle; writes leave r3 then r4.
// - T4 full/wrap: wb_hold=1, 5 ALU writes r1..r5 -> 4 accepted, then both ready=0; release hold ->
//   r1..r4 drain on 4 consecutive cycles, r5 then accepted; repeat 3x to exercise pointer wrap.
// - T5 forwarding: hold, queue r7=16'h0001 then r7=16'h0002 -> fwd_raddr_1=7 gives hit=1, data=16'h0002;
//   fwd_raddr_2=8 gives hit=0, data=0.
// - T6 r0/reset mid-queue: with DROP_R0=1, alu r0=16'hFFFF is accepted and never written;
//   with 3 entries queued, arst_n=0 -> next cycle count=0 and no further reg_write.

Source files
------------

// File: rtl/writeback_queue.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | writeback_queue: in-order write queue in front of the register file,     |
// | with two forwarding lookup ports.          Rev 1.0                       |
// +--------------------------------------------------------------------------+
module writeback_queue #(
   parameter int DATA_W  = 16,
   parameter int DEPTH   = 4,
   parameter bit DROP_R0 = 1'b1
) (
   input  logic              clk,
   input  logic              arst_n,
   input  logic              mem_valid,
   output logic              mem_ready,
   input  logic [4:0]        mem_waddr,
   input  logic [DATA_W-1:0] mem_wdata,
   input  logic              alu_valid,
   output logic              alu_ready,
   input  logic [4:0]        alu_waddr,
   input  logic [DATA_W-1:0] alu_wdata,
   input  logic              wb_hold,
   output logic              reg_write,
   output logic [4:0]        waddr,
   output logic [DATA_W-1:0] wdata,
   input  logic [4:0]        fwd_raddr_1,
   input  logic [4:0]        fwd_raddr_2,
   output logic              fwd_hit_1,
   output logic              fwd_hit_2,
   output logic [DATA_W-1:0] fwd_data_1,
   output logic [DATA_W-1:0] fwd_data_2,
   output logic              wb_idle
);

   localparam int c_pw = $clog2(DEPTH);
   localparam int c_cw = c_pw + 1;
   localparam logic [c_cw-1:0] c_full = c_cw'(DEPTH);

   logic [4:0]        r_addr [DEPTH];
   logic [DATA_W-1:0] r_data [DEPTH];
   logic [c_pw-1:0]   r_wr_ptr;
   logic [c_pw-1:0]   r_rd_ptr;
   logic [c_cw-1:0]   r_count;

   logic              w_full;
   logic              w_empty;
   logic              w_acc_mem;
   logic              w_acc_alu;
   logic [4:0]        w_enq_addr;
   logic [DATA_W-1:0] w_enq_data;
   logic              w_push;
   logic              w_pop;
   logic [c_pw-1:0]   w_idx;

   assign w_full  = (r_count == c_full);
   assign w_empty = (r_count == '0);

   // Ready depends only on the stored count, so a full queue never passes through.
   assign mem_ready = !w_full;
   assign alu_ready = !w_full && !mem_valid;

   assign w_acc_mem  = mem_valid && mem_ready;
   assign w_acc_alu  = alu_valid && alu_ready;
   assign w_enq_addr = w_acc_mem ? mem_waddr : alu_waddr;
   assign w_enq_data = w_acc_mem ? mem_wdata : alu_wdata;
   assign w_push     = (w_acc_mem || w_acc_alu) && !(DROP_R0 && (w_enq_addr == 5'd0));

   assign reg_write = !w_empty && !wb_hold;
   assign w_pop     = reg_write;
   assign waddr     = w_empty ? 5'd0 : r_addr[r_rd_ptr];
   assign wdata     = w_empty ? '0 : r_data[r_rd_ptr];
   assign wb_idle   = w_empty;

   always_ff @(posedge clk) begin
      if (!arst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            r_addr[i] <= 5'd0;
            r_data[i] <= '0;
         end
      end else begin
         if (w_push) begin
            r_addr[r_wr_ptr] <= w_enq_addr;
            r_data[r_wr_ptr] <= w_enq_data;
            r_wr_ptr         <= r_wr_ptr + c_pw'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + c_pw'(1);
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + c_cw'(1);
            2'b01:   r_count <= r_count - c_cw'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   // Scan oldest to youngest so the youngest matching entry overrides older ones.
   always_comb begin
      fwd_hit_1  = 1'b0;
      fwd_hit_2  = 1'b0;
      fwd_data_1 = '0;
      fwd_data_2 = '0;
      w_idx      = r_rd_ptr;
      for (int i = 0; i < DEPTH; i++) begin
         w_idx = r_rd_ptr + c_pw'(i);
         if (c_cw'(i) < r_count) begin
            if (r_addr[w_idx] == fwd_raddr_1) begin
               fwd_hit_1  = 1'b1;
               fwd_data_1 = r_data[w_idx];
            end
            if (r_addr[w_idx] == fwd_raddr_2) begin
               fwd_hit_2  = 1'b1;
               fwd_data_2 = r_data[w_idx];
            end
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_writeback_queue.sv
`default_nettype none
// Bench for writeback_queue: queue-based reference model checked every cycle,
// plus directed literal expectations.
module tb_writeback_queue;

   localparam int DATA_W  = 16;
   localparam int DEPTH   = 4;
   localparam bit DROP_R0 = 1'b1;

   logic              clk = 1'b0;
   logic              arst_n;
   logic              mem_valid, mem_ready, alu_valid, alu_ready;
   logic [4:0]        mem_waddr, alu_waddr, waddr, fwd_raddr_1, fwd_raddr_2;
   logic [DATA_W-1:0] mem_wdata, alu_wdata, wdata, fwd_data_1, fwd_data_2;
   logic              wb_hold, reg_write, fwd_hit_1, fwd_hit_2, wb_idle;

   writeback_queue #(.DATA_W(DATA_W), .DEPTH(DEPTH), .DROP_R0(DROP_R0)) dut (
      .clk(clk), .arst_n(arst_n),
      .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
      .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_waddr(alu_waddr), .alu_wdata(alu_wdata),
      .wb_hold(wb_hold), .reg_write(reg_write), .waddr(waddr), .wdata(wdata),
      .fwd_raddr_1(fwd_raddr_1), .fwd_raddr_2(fwd_raddr_2),
      .fwd_hit_1(fwd_hit_1), .fwd_hit_2(fwd_hit_2),
      .fwd_data_1(fwd_data_1), .fwd_data_2(fwd_data_2), .wb_idle(wb_idle)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [4:0]        a;
      logic [DATA_W-1:0] d;
   } ent_t;

   ent_t mq[$];
   int   n_checks = 0;
   int   n_fail   = 0;
   bit   started  = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
      end
   endtask

   function automatic void mfwd(input logic [4:0] ra, output logic h, output logic [DATA_W-1:0] d);
      h = 1'b0;
      d = '0;
      foreach (mq[i]) begin
         if (mq[i].a == ra) begin
            h = 1'b1;
            d = mq[i].d;
         end
      end
   endfunction

   // Reference model: a plain in-order queue updated at each rising edge.
   always @(posedge clk) begin : model
      bit full, pop, am, aa;
      if (!arst_n) begin
         mq.delete();
      end else begin
         full = (mq.size() == DEPTH);
         pop  = (mq.size() != 0) && !wb_hold;
         am   = mem_valid && !full;
         aa   = alu_valid && !full && !mem_valid;
         if (pop) void'(mq.pop_front());
         if (am && !(DROP_R0 && mem_waddr == 5'd0))
            mq.push_back('{a: mem_waddr, d: mem_wdata});
         else if (aa && !(DROP_R0 && alu_waddr == 5'd0))
            mq.push_back('{a: alu_waddr, d: alu_wdata});
      end
   end

   always @(negedge clk) begin : compare
      int                sz;
      logic              h1, h2;
      logic [DATA_W-1:0] d1, d2;
      if (started) begin
         sz = mq.size();
         mfwd(fwd_raddr_1, h1, d1);
         mfwd(fwd_raddr_2, h2, d2);
         check("mem_ready", 32'(mem_ready), 32'(sz != DEPTH));
         check("alu_ready", 32'(alu_ready), 32'(sz != DEPTH && !mem_valid));
         check("reg_write", 32'(reg_write), 32'(sz != 0 && !wb_hold));
         check("waddr", 32'(waddr), (sz != 0) ? 32'(mq[0].a) : 32'd0);
         check("wdata", 32'(wdata), (sz != 0) ? 32'(mq[0].d) : 32'd0);
         check("fwd_hit_1", 32'(fwd_hit_1), 32'(h1));
         check("fwd_data_1", 32'(fwd_data_1), 32'(d1));
         check("fwd_hit_2", 32'(fwd_hit_2), 32'(h2));
         check("fwd_data_2", 32'(fwd_data_2), 32'(d2));
         check("wb_idle", 32'(wb_idle), 32'(sz == 0));
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic alu_drive(input logic v, input logic [4:0] a, input logic [DATA_W-1:0] d);
      alu_valid = v;
      alu_waddr = a;
      alu_wdata = d;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      arst_n = 1'b0; wb_hold = 1'b0;
      mem_valid = 1'b1; mem_waddr = 5'd3; mem_wdata = 16'h1111;
      alu_valid = 1'b1; alu_waddr = 5'd4; alu_wdata = 16'h2222;
      fwd_raddr_1 = 5'd3; fwd_raddr_2 = 5'd4;

      // T1: reset with both sources valid
      tick();
      started = 1'b1;
      tick();
      check("t1_reg_write", 32'(reg_write), 32'd0);
      check("t1_wb_idle", 32'(wb_idle), 32'd1);
      check("t1_fwd_hit_1", 32'(fwd_hit_1), 32'd0);
      check("t1_fwd_hit_2", 32'(fwd_hit_2), 32'd0);
      check("t1_waddr", 32'(waddr), 32'd0);
      arst_n = 1'b1; mem_valid = 1'b0; alu_valid = 1'b0;
      tick();
      check("t1_idle_after", 32'(wb_idle), 32'd1);

      // T2: single ALU write
      alu_drive(1'b1, 5'd5, 16'h1234);
      tick();
      alu_valid = 1'b0;
      #1;
      check("t2_reg_write", 32'(reg_write), 32'd1);
      check("t2_waddr", 32'(waddr), 32'd5);
      check("t2_wdata", 32'(wdata), 32'h1234);
      tick();
      check("t2_idle", 32'(wb_idle), 32'd1);

      // T3: memory has priority
      mem_valid = 1'b1; mem_waddr = 5'd3; mem_wdata = 16'hAAAA;
      alu_drive(1'b1, 5'd4, 16'h5555);
      #1;
      check("t3_alu_ready", 32'(alu_ready), 32'd0);
      check("t3_mem_ready", 32'(mem_ready), 32'd1);
      tick();
      mem_valid = 1'b0;
      #1;
      check("t3_waddr_first", 32'(waddr), 32'd3);
      check("t3_wdata_first", 32'(wdata), 32'hAAAA);
      check("t3_alu_ready2", 32'(alu_ready), 32'd1);
      tick();
      alu_valid = 1'b0;
      #1;
      check("t3_waddr_second", 32'(waddr), 32'd4);
      check("t3_wdata_second", 32'(wdata), 32'h5555);
      tick();
      check("t3_idle", 32'(wb_idle), 32'd1);

      // T4: fill under hold, then drain; three rounds wrap the pointers
      for (int r = 0; r < 3; r++) begin
         wb_hold = 1'b1;
         for (int k = 1; k <= 4; k++) begin
            alu_drive(1'b1, 5'(k), 16'(r * 16 + k));
            tick();
         end
         alu_drive(1'b1, 5'd5, 16'(r * 16 + 5));
         #1;
         check("t4_alu_ready_full", 32'(alu_ready), 32'd0);
         check("t4_mem_ready_full", 32'(mem_ready), 32'd0);
         tick();
         check("t4_still_full", 32'(alu_ready), 32'd0);
         wb_hold = 1'b0;
         #1;
         check("t4_rw_release", 32'(reg_write), 32'd1);
         check("t4_head_r1", 32'(waddr), 32'd1);
         check("t4_no_passthru", 32'(alu_ready), 32'd0);
         tick();
         check("t4_head_r2", 32'(waddr), 32'd2);
         check("t4_ready_again", 32'(alu_ready), 32'd1);
         tick();
         alu_valid = 1'b0;
         #1;
         check("t4_head_r3", 32'(waddr), 32'd3);
         tick();
         check("t4_head_r4", 32'(waddr), 32'd4);
         tick();
         check("t4_head_r5", 32'(waddr), 32'd5);
         check("t4_data_r5", 32'(wdata), 32'(r * 16 + 5));
         tick();
         check("t4_idle", 32'(wb_idle), 32'd1);
      end

      // T5: forwarding, youngest wins, enqueue not visible until next cycle
      wb_hold = 1'b1;
      fwd_raddr_1 = 5'd7; fwd_raddr_2 = 5'd8;
      alu_drive(1'b1, 5'd7, 16'h0001);
      tick();
      alu_drive(1'b1, 5'd7, 16'h0002);
      tick();
      alu_valid = 1'b0;
      #1;
      check("t5_hit_1", 32'(fwd_hit_1), 32'd1);
      check("t5_data_1", 32'(fwd_data_1), 32'h0002);
      check("t5_hit_2", 32'(fwd_hit_2), 32'd0);
      check("t5_data_2", 32'(fwd_data_2), 32'd0);
      alu_drive(1'b1, 5'd8, 16'hBEEF);
      #1;
      check("t5_enq_invisible", 32'(fwd_hit_2), 32'd0);
      tick();
      alu_valid = 1'b0;
      #1;
      check("t5_enq_visible", 32'(fwd_hit_2), 32'd1);
      check("t5_enq_data", 32'(fwd_data_2), 32'hBEEF);
      wb_hold = 1'b0;
      fwd_raddr_1 = 5'd7;
      #1;
      check("t5_head_still_hit", 32'(fwd_hit_1), 32'd1);
      tick(); tick(); tick();
      check("t5_idle", 32'(wb_idle), 32'd1);

      // T6: r0 write is dropped; reset discards a partly filled queue
      alu_drive(1'b1, 5'd0, 16'hFFFF);
      #1;
      check("t6_r0_ready", 32'(alu_ready), 32'd1);
      tick();
      alu_valid = 1'b0;
      #1;
      check("t6_r0_idle", 32'(wb_idle), 32'd1);
      check("t6_r0_no_write", 32'(reg_write), 32'd0);
      tick();
      wb_hold = 1'b1;
      for (int k = 9; k <= 11; k++) begin
         alu_drive(1'b1, 5'(k), 16'(16'h0900 + k));
         tick();
      end
      alu_valid = 1'b0;
      fwd_raddr_1 = 5'd9;
      #1;
      check("t6_queued", 32'(wb_idle), 32'd0);
      check("t6_fwd_before", 32'(fwd_hit_1), 32'd1);
      arst_n = 1'b0; wb_hold = 1'b0;
      mem_valid = 1'b1; mem_waddr = 5'd12; mem_wdata = 16'h0C0C;
      tick();
      check("t6_rst_idle", 32'(wb_idle), 32'd1);
      check("t6_rst_no_write", 32'(reg_write), 32'd0);
      check("t6_rst_fwd", 32'(fwd_hit_1), 32'd0);
      arst_n = 1'b1; mem_valid = 1'b0;
      tick(); tick();
      check("t6_after_rw", 32'(reg_write), 32'd0);
      check("t6_after_idle", 32'(wb_idle), 32'd1);

      @(negedge clk);
      #1;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
